pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter LU_STALL, default 1, number of bubble cycles inserted for a load-use hazard (legal range 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 id_rs, id_rt  input  6 each  source register numbers of the instruction in IF/ID.
REQ-005 id_uses_rs, id_uses_rt  input  1 each  decode qualifies each source as actually read.
REQ-006 ex_rd  input  6  destination register of the instruction in ID/EX.
REQ-007 ex_MemRead  input  1  instruction in ID/EX is a load.
REQ-008 ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-009 ext_hold  input  1  external freeze request (memory not ready).
REQ-010 pc_en, ifid_en, idex_en, exwb_en  output  1 each  load enables for PC and the three pipeline buffers.
REQ-011 ifid_flush  output  1  IF/ID loads a NOP instead of the fetched instruction.
REQ-012 idex_bubble  output  1  ID/EX loads all-zero control signals.
REQ-013 stall_cnt, flush_cnt  output  16 each  hazard statistics (see Configuration).

Function
REQ-014 States: RUN, STALL, HOLD; plus 3-bit bubble counter cnt and 1-bit saved state ret.
REQ-015 Load-use hazard lu = ex_MemRead & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
REQ-016 Event priority per cycle, highest first: ext_hold, ex_branch_taken, lu.
REQ-017 RUN, no event: all four enables 1, ifid_flush 0, idex_bubble 0.
REQ-018 RUN or STALL, ex_branch_taken (no hold): pc_en, ifid_en, idex_en, exwb_en 1, ifid_flush 1, idex_bubble 1; next state RUN, cnt cleared.
REQ-019 RUN, lu (no hold, no branch): pc_en 0, ifid_en 0, idex_en 1, idex_bubble 1, exwb_en 1; if LU_STALL = 1 stay RUN, else next STALL with cnt = LU_STALL-1.
REQ-020 STALL, no event: same outputs as REQ-019; cnt decrements; when cnt = 1 next state RUN.
REQ-021 Any state, ext_hold: all enables 0, ifid_flush 0, idex_bubble 0; entering HOLD saves current state into ret; cnt frozen.
REQ-022 HOLD, ext_hold deasserts: outputs evaluated as in state ret that same cycle; next state per ret's rules.
REQ-023 Outputs are combinational from state and current inputs; no added latency; ex_branch_taken and lu both high resolves as branch only.
REQ-024 lu re-detected in RUN immediately after a STALL completes starts a new stall (back-to-back loads).

Reset
REQ-025 While rst high: state RUN, cnt 0, ret RUN, stall_cnt 0, flush_cnt 0; all enables 0, ifid_flush 1, idex_bubble 1.
REQ-026 rst asserted mid-STALL or mid-HOLD abandons the sequence; first cycle after release behaves as RUN.

Configuration
REQ-027 Macro HAZARD_STATS_EN defined: stall_cnt increments on each cycle pc_en=0 with ext_hold=0; flush_cnt increments on each cycle ifid_flush=1 outside reset; both saturate at 16'hFFFF.
REQ-028 Macro HAZARD_STATS_EN undefined: no counter registers; stall_cnt and flush_cnt tied to 0.

Verification
REQ-029 ex_MemRead=1, ex_rd=5, id_rs=5, id_uses_rs=1, LU_STALL=1 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1, then RUN outputs.
REQ-030 Same hazard with LU_STALL=3 -> exactly 3 bubble cycles; stall_cnt=3 with HAZARD_STATS_EN.
REQ-031 ex_branch_taken=1 concurrent with lu=1 -> ifid_flush=1, idex_bubble=1, pc_en=1; no stall follows; flush_cnt=1.
REQ-032 ext_hold=1 for 4 cycles during cycle 2 of a LU_STALL=3 stall -> all enables 0 for 4 cycles, then 2 remaining bubble cycles.
REQ-033 ex_rd=0 with load and matching id_rs=0 -> no stall; rst pulse mid-STALL -> reset outputs per REQ-025, then RUN.
REQ-034 2^16+5 flushes with HAZARD_STATS_EN -> flush_cnt=16'hFFFF; without macro -> both counters read 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline hazard control (load-use stall, branch flush, external hold).
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module pipeline_ctrl #(
  parameter int LU_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  id_rs,
  input  logic [5:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [5:0]  ex_rd,
  input  logic        ex_MemRead,
  input  logic        ex_branch_taken,
  input  logic        ext_hold,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exwb_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, STALL, HOLD} state_t;
  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt;
  logic       r_ret, w_ret;
  logic       w_lu, w_in_stall;
  assign w_lu = ex_MemRead & (ex_rd != '0) &
                ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  // leaving HOLD behaves as the saved state in the same cycle
  assign w_in_stall = (r_state == STALL) | ((r_state == HOLD) & r_ret);
  always_comb begin
    w_next      = r_state;
    w_cnt       = r_cnt;
    w_ret       = r_ret;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exwb_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exwb_en} = 4'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      w_next      = RUN;
      w_cnt       = '0;
      w_ret       = 1'b0;
    end else if (ext_hold) begin
      {pc_en, ifid_en, idex_en, exwb_en} = 4'b0;
      w_next = HOLD;
      w_ret  = (r_state == HOLD) ? r_ret : (r_state == STALL);
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      w_next      = RUN;
      w_cnt       = '0;
    end else if (w_in_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      w_cnt       = r_cnt - 3'd1;
      w_next      = (r_cnt == 3'd1) ? RUN : STALL;
    end else if (w_lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      w_cnt       = 3'(LU_STALL - 1);
      w_next      = (LU_STALL == 1) ? RUN : STALL;
    end else begin
      w_next = RUN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_ret   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_ret   <= w_ret;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && !ext_hold && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (ifid_flush && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized and directed stimulus, scoreboard checked against a bubble-count reference model.
module tb_pipeline_ctrl;
  localparam int LU = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, ex_MemRead = 0, ex_branch_taken = 0, ext_hold = 0;
  logic pc_en, ifid_en, idex_en, exwb_en, ifid_flush, idex_bubble;
  logic [15:0] stall_cnt, flush_cnt;
  pipeline_ctrl #(.LU_STALL(LU)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .ex_branch_taken(ex_branch_taken), .ext_hold(ext_hold), .pc_en(pc_en),
    .ifid_en(ifid_en), .idex_en(idex_en), .exwb_en(exwb_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  typedef struct { logic [5:0] ctl; logic [15:0] sc, fc; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int rem = 0, m_sc = 0, m_fc = 0;
  // {pc, ifid, idex, exwb, flush, bubble}
  task automatic step(input logic r, h, b, mr, input logic [5:0] rd, rs, rt,
                      input logic urs, urt);
    exp_t e;
    logic lu;
    @(posedge clk); #1;
    rst = r; ext_hold = h; ex_branch_taken = b; ex_MemRead = mr;
    ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    #1;
    lu = mr && rd != 0 && ((urs && rs == rd) || (urt && rt == rd));
    if (r) begin
      rem = 0; m_sc = 0; m_fc = 0;
      e.ctl = 6'b000011;
    end else if (h) e.ctl = 6'b000000;
    else if (b) begin e.ctl = 6'b111111; rem = 0; end
    else if (rem > 0) begin e.ctl = 6'b001101; rem--; end
    else if (lu) begin e.ctl = 6'b001101; rem = LU - 1; end
    else e.ctl = 6'b111100;
`ifdef HAZARD_STATS_EN
    e.sc = 16'(m_sc); e.fc = 16'(m_fc);
    if (!r) begin
      if (!e.ctl[5] && !h && m_sc < 65535) m_sc++;
      if (e.ctl[1] && m_fc < 65535) m_fc++;
    end
`else
    e.sc = 16'd0; e.fc = 16'd0;
`endif
    q.push_back(e);
  endtask
  task automatic idle(input logic h, b);
    step(0, h, b, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic hazard(input logic h, b);
    step(0, h, b, 1, 6'd5, 6'd5, 6'd9, 1, 0);
  endtask
  initial begin : monitor
    exp_t e;
    logic [5:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {pc_en, ifid_en, idex_en, exwb_en, ifid_flush, idex_bubble};
        checks++;
        if (got !== e.ctl) begin
          failures++;
          $display("FAIL ctrl t=%0t got=%b exp=%b", $time, got, e.ctl);
        end
        checks++;
        if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
          failures++;
          $display("FAIL stats t=%0t got=%0d/%0d exp=%0d/%0d", $time, stall_cnt, flush_cnt, e.sc, e.fc);
        end
      end
    end
  end
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 6'd5, 6'd5, 0, 1, 0);
    idle(0, 0);
    hazard(0, 0); repeat (4) idle(0, 0);
    hazard(0, 1); repeat (3) idle(0, 0);
    hazard(0, 0); hazard(0, 0);
    repeat (4) idle(1, 0);
    repeat (3) idle(0, 0);
    hazard(0, 0); hazard(0, 0); hazard(0, 0); hazard(0, 0); idle(0, 0);
    step(0, 0, 0, 1, 6'd0, 6'd0, 6'd0, 1, 1); idle(0, 0);
    hazard(0, 0); hazard(0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    hazard(0, 0); idle(0, 0); idle(0, 0); idle(0, 0);
    hazard(0, 0); hazard(1, 0); hazard(1, 1); hazard(0, 1); idle(0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
           6'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end
`ifdef HAZARD_STATS_EN
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65541; i++) idle(0, 1);
    idle(0, 0);
`endif
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
